rob_wb_arbiter: RTL and testbench

//  Shares the single ROB result-write port between the three execute-stage writeback sources.
//  The sources are req 0 = ALU, req 1 = forwarder/mem and req 2 = jump unit.

---
 rtl/core_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/rob_wb_arbiter.sv | 112 +++++++++++
 tb/tb_rob_wb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants for the writeback/ROB interface.
// The all-ones tag is reserved as "no entry", so the ROB holds one entry fewer than the tag space.
package core_pkg;

    localparam int N_REQ         = 3;
    localparam int TAG_W         = 4;
    localparam int DATA_W        = 32;
    localparam int PTR_W         = $clog2(N_REQ);
    localparam int ROB_ENTRY_NUM = 15;

    localparam logic [TAG_W-1:0] TAG_INVALID = TAG_W'(ROB_ENTRY_NUM);

    typedef enum logic [1:0] {
        OP_ALU  = 2'd0,
        OP_MEM  = 2'd1,
        OP_JUMP = 2'd2
    } op_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } wb_req_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] next_pc;
        logic              is_jump;
    } rob_wr_t;

    function automatic logic tag_ok(input logic [TAG_W-1:0] tag);
        return (tag != TAG_INVALID);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr
// and reports the pointer position just past the winner.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] next_ptr
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // Rotating priority scan starting at ptr.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = PTR_W'((int'(ptr) + k) % N);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                next_ptr     = PTR_W'((int'(idx_s) + 1) % N);
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter sharing the ROB result-write port between ALU, mem and jump
// writeback sources, with a one-deep registered output stage.
module rob_wb_arbiter
    import core_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_val,
    input  logic [DATA_W-1:0]       req_next_pc,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [TAG_W-1:0]        wr_tag,
    output logic [DATA_W-1:0]       wr_val,
    output logic [DATA_W-1:0]       wr_next_pc,
    output logic                    wr_is_jump,
    output logic                    proto_err
);

    wb_req_t          req_s [N_REQ];
    logic [N_REQ-1:0] eligible_s;
    logic [N_REQ-1:0] grant_s;
    logic             bad_tag_s;
    logic             can_load_s;
    logic             load_s;
    wb_req_t          sel_s;
    logic             sel_jump_s;
    logic [PTR_W-1:0] next_ptr_s;
    logic [PTR_W-1:0] rr_ptr_r;
    rob_wr_t          wr_r;
    logic             proto_err_r;

    // Unpack requester buses; invalid-tag requests are masked out of arbitration.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_s[i].tag  = req_tag[i*TAG_W +: TAG_W];
            req_s[i].val  = req_val[i*DATA_W +: DATA_W];
            eligible_s[i] = req_valid[i] & tag_ok(req_s[i].tag);
        end
        bad_tag_s = |(req_valid & ~eligible_s);
    end

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req      (eligible_s),
        .ptr      (rr_ptr_r),
        .grant    (grant_s),
        .next_ptr (next_ptr_s)
    );

    // Handshake gating and winner select.
    always_comb begin
        can_load_s = ~rst & ~flush & (~wr_r.valid | wr_ready);
        req_ready  = grant_s & {N_REQ{can_load_s}};
        load_s     = |req_ready;
        sel_s      = '0;
        sel_jump_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                sel_s      = req_s[i];
                sel_jump_s = (i == int'(OP_JUMP));
            end else begin
                sel_s      = sel_s;
                sel_jump_s = sel_jump_s;
            end
        end
    end

    // Output stage, round-robin pointer and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r.valid   <= 1'b0;
            wr_r.tag     <= TAG_INVALID;
            wr_r.val     <= {DATA_W{1'b0}};
            wr_r.next_pc <= {DATA_W{1'b0}};
            wr_r.is_jump <= 1'b0;
            rr_ptr_r     <= {PTR_W{1'b0}};
            proto_err_r  <= 1'b0;
        end else begin
            proto_err_r <= proto_err_r | bad_tag_s;
            if (flush) begin
                // A flush kills the pending write even if the ROB is taking it this cycle.
                wr_r.valid <= 1'b0;
                rr_ptr_r   <= {PTR_W{1'b0}};
            end else if (load_s) begin
                wr_r.valid   <= 1'b1;
                wr_r.tag     <= sel_s.tag;
                wr_r.val     <= sel_s.val;
                wr_r.is_jump <= sel_jump_s;
                wr_r.next_pc <= sel_jump_s ? req_next_pc : wr_r.next_pc;
                rr_ptr_r     <= next_ptr_s;
            end else if (wr_ready) begin
                wr_r.valid <= 1'b0;
            end else begin
                wr_r <= wr_r;
            end
        end
    end

    assign wr_valid   = wr_r.valid;
    assign wr_tag     = wr_r.tag;
    assign wr_val     = wr_r.val;
    assign wr_next_pc = wr_r.next_pc;
    assign wr_is_jump = wr_r.is_jump;
    assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: expected ROB writes go into a scoreboard queue
// and a negedge monitor checks each write the ROB accepts.
module tb_rob_wb_arbiter;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] val;
        logic        jmp;
        logic [31:0] npc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [11:0] req_tag;
    logic [95:0] req_val;
    logic [31:0] req_next_pc;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_tag;
    logic [31:0] wr_val;
    logic [31:0] wr_next_pc;
    logic        wr_is_jump;
    logic        proto_err;

    int   checks;
    int   errors;
    exp_t sb_q[$];
    exp_t mon_e;

    rob_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tag     (req_tag),
        .req_val     (req_val),
        .req_next_pc (req_next_pc),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_tag      (wr_tag),
        .wr_val      (wr_val),
        .wr_next_pc  (wr_next_pc),
        .wr_is_jump  (wr_is_jump),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] tag, input logic [31:0] val,
                        input logic jmp, input logic [31:0] npc);
        exp_t e;
        e.tag = tag;
        e.val = val;
        e.jmp = jmp;
        e.npc = npc;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [3:0] tag, input logic [31:0] val);
        req_tag[i*4 +: 4]  = tag;
        req_val[i*32 +: 32] = val;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every write accepted by the ROB must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && wr_valid === 1'b1 && wr_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual_tag=%0h required=none", wr_tag);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_tag", wr_tag, mon_e.tag);
                chk("sb_val", wr_val, mon_e.val);
                chk("sb_jump", wr_is_jump, mon_e.jmp);
                if (mon_e.jmp) chk("sb_next_pc", wr_next_pc, mon_e.npc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        req_valid   = 3'b000;
        req_tag     = 12'h000;
        req_val     = 96'h0;
        req_next_pc = 32'h0;
        wr_ready    = 1'b1;

        // 1. Reset: requests during reset must not be granted.
        step();
        req_valid = 3'b111;
        req_tag   = {4'd3, 4'd2, 4'd1};
        sample();
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_proto", proto_err, 1'b0);
        chk("rst_tag", wr_tag, 4'hF);
        chk("rst_val", wr_val, 32'h0);
        chk("rst_npc", wr_next_pc, 32'h0);
        chk("rst_jump", wr_is_jump, 1'b0);
        step();
        sample();
        chk("rst2_ready", req_ready, 3'b000);
        step();
        rst       = 1'b0;
        req_valid = 3'b000;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("idle_valid", wr_valid, 1'b0);
            chk("idle_ready", req_ready, 3'b000);
            chk("idle_proto", proto_err, 1'b0);
            step();
        end

        // 2. Single ALU write.
        set_req(0, 4'd5, 32'hDEAD_BEEF);
        req_valid = 3'b001;
        push(4'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
        sample();
        chk("alu_ready", req_ready, 3'b001);
        step();
        req_valid = 3'b000;
        sample();
        chk("alu_wr_valid", wr_valid, 1'b1);
        chk("alu_wr_tag", wr_tag, 4'd5);
        chk("alu_wr_val", wr_val, 32'hDEAD_BEEF);
        chk("alu_wr_jump", wr_is_jump, 1'b0);
        step();
        sample();
        chk("alu_drain", wr_valid, 1'b0);
        step();

        // Idle flush returns the pointer (currently 1) to requester 0.
        flush = 1'b1;
        sample();
        chk("flush_idle_ready", req_ready, 3'b000);
        step();
        flush = 1'b0;

        // 3. Round-robin with all three requesters valid.
        set_req(0, 4'd1, 32'hA0);
        set_req(1, 4'd2, 32'hA1);
        set_req(2, 4'd3, 32'hA2);
        req_next_pc = 32'h0;
        req_valid   = 3'b111;
        for (int k = 0; k < 6; k++) begin
            sample();
            chk("rr_grant", req_ready, 3'b001 << (k % 3));
            chk("rr_no_bubble", wr_valid, (k != 0));
            push(4'(k % 3 + 1), 32'hA0 + 32'(k % 3), (k % 3) == 2, 32'h0);
            step();
        end
        req_valid = 3'b000;
        sample();
        chk("rr_last_tag", wr_tag, 4'd3);
        step();
        sample();
        chk("rr_drain", wr_valid, 1'b0);
        step();

        // 4. Back-pressure.
        set_req(0, 4'd6, 32'h66);
        req_valid = 3'b001;
        push(4'd6, 32'h66, 1'b0, 32'h0);
        sample();
        chk("bp_first_ready", req_ready, 3'b001);
        step();
        wr_ready = 1'b0;
        set_req(1, 4'd7, 32'h77);
        req_valid = 3'b010;
        for (int j = 0; j < 3; j++) begin
            sample();
            chk("bp_valid", wr_valid, 1'b1);
            chk("bp_tag", wr_tag, 4'd6);
            chk("bp_val", wr_val, 32'h66);
            chk("bp_ready", req_ready, 3'b000);
            step();
        end
        wr_ready = 1'b1;
        push(4'd7, 32'h77, 1'b0, 32'h0);
        sample();
        chk("bp_release_ready", req_ready, 3'b010);
        step();
        req_valid = 3'b000;
        sample();
        chk("bp_next_tag", wr_tag, 4'd7);
        step();
        sample();
        chk("bp_drain", wr_valid, 1'b0);
        step();

        // 5. Jump write, then flush while the ROB is accepting it.
        set_req(2, 4'd9, 32'h100);
        req_next_pc = 32'h200;
        req_valid   = 3'b100;
        push(4'd9, 32'h100, 1'b1, 32'h200);
        sample();
        chk("jmp_ready", req_ready, 3'b100);
        step();
        flush = 1'b1;
        set_req(0, 4'd10, 32'hAA);
        set_req(1, 4'd11, 32'hBB);
        req_next_pc = 32'h0;
        req_valid   = 3'b011;
        sample();
        chk("jmp_is_jump", wr_is_jump, 1'b1);
        chk("jmp_next_pc", wr_next_pc, 32'h200);
        chk("flush_ready", req_ready, 3'b000);
        step();
        flush = 1'b0;
        push(4'd10, 32'hAA, 1'b0, 32'h0);
        sample();
        chk("flush_drop", wr_valid, 1'b0);
        chk("flush_ptr_grant", req_ready, 3'b001);
        step();
        req_valid = 3'b000;
        sample();
        chk("post_flush_tag", wr_tag, 4'd10);
        chk("post_flush_npc_hold", wr_next_pc, 32'h200);
        step();
        sample();
        chk("post_flush_drain", wr_valid, 1'b0);
        step();

        // 6. Invalid tag.
        set_req(1, 4'hF, 32'h55);
        req_valid = 3'b010;
        sample();
        chk("bad_ready", req_ready, 3'b000);
        chk("bad_proto_early", proto_err, 1'b0);
        step();
        sample();
        chk("bad_proto", proto_err, 1'b1);
        chk("bad_ready2", req_ready, 3'b000);
        chk("bad_wr_valid", wr_valid, 1'b0);
        step();
        req_valid = 3'b000;
        for (int j = 0; j < 3; j++) begin
            sample();
            chk("bad_sticky", proto_err, 1'b1);
            step();
        end

        // Reset while a write is pending discards it.
        set_req(0, 4'd3, 32'h33);
        req_valid = 3'b001;
        wr_ready  = 1'b0;
        sample();
        chk("mid_ready", req_ready, 3'b001);
        step();
        req_valid = 3'b000;
        rst       = 1'b1;
        sample();
        chk("mid_loaded", wr_valid, 1'b1);
        chk("mid_rst_ready", req_ready, 3'b000);
        step();
        sample();
        chk("mid_rst_valid", wr_valid, 1'b0);
        chk("mid_rst_proto", proto_err, 1'b0);
        chk("mid_rst_tag", wr_tag, 4'hF);
        step();
        rst      = 1'b0;
        wr_ready = 1'b1;
        sample();
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
